uart_receiver: RTL and testbench
================================

UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 clk  input  1  single system clock; all state updates on rising edge.
REQ-002 reset  input  1  asynchronous, active-low reset; reset=0 forces reset state immediately.
REQ-003 baud_select  input  3  baud rate code, passed unchanged to an internal Baud_controller instance (same codes as transmitter).
REQ-004 Rx_EN  input  1  receiver enable; 0 holds block in OFF.
REQ-005 RxD  input  1  asynchronous serial line, idle high.
REQ-006 Rx_DATA  output  8  last correctly received byte.
REQ-007 Rx_VALID  output  1  one-clk pulse when Rx_DATA is updated with an error-free byte.
REQ-008 Rx_PERROR  output  1  parity error flag for last frame.
REQ-009 Rx_FERROR  output  1  framing error flag (stop bit sampled 0) for last frame.

Function
REQ-010 Frame format SHALL be: start bit 0, data bits D0..D7 LSB first, parity bit = XOR of D7..D0 (same as transmitter), stop bit 1.
REQ-011 Bit timing SHALL use Baud_controller sample_ENABLE, 16 ticks per bit period; a 4-bit oversample counter advances only on ticks.
REQ-012 RxD SHALL pass a 2-flop synchronizer; all decisions use the synchronized value (2-clk input latency).
REQ-013 States SHALL be OFF, IDLE, START, DATA, PARITY, STOP, plus a bit index 0..7 for DATA.
REQ-014 OFF -> IDLE when Rx_EN=1; any state -> OFF on the clock after Rx_EN=0, discarding the partial frame, no Rx_VALID, outputs held.
REQ-015 IDLE: on synchronized RxD=0, go START, clear oversample counter, clear Rx_PERROR and Rx_FERROR.
REQ-016 START: on the tick where counter reaches 7 (bit midpoint), RxD=0 -> DATA with counter cleared and bit index 0; RxD=1 -> IDLE (false start, flags stay clear, no Rx_VALID).
REQ-017 DATA: on each tick where counter reaches 15, sample RxD into shift register at position of bit index; after bit 7 go PARITY.
REQ-018 PARITY: at counter 15, sample parity; mismatch with XOR of received bits records parity error internally; go STOP.
REQ-019 STOP: at counter 15, sample stop bit; then go IDLE on the next clock.
REQ-020 Stop=1 and parity ok: Rx_DATA <= received byte and Rx_VALID=1 for exactly one clk, same edge.
REQ-021 Stop=1, parity bad: Rx_PERROR=1, Rx_DATA unchanged, no Rx_VALID.
REQ-022 Stop=0: Rx_FERROR=1 (Rx_PERROR also set if parity bad), Rx_DATA unchanged, no Rx_VALID; block SHALL then wait in IDLE until synchronized RxD=1 before accepting a new start edge (break/stuck-low guard).
REQ-023 Error flags SHALL hold until the next accepted start edge or reset.
REQ-024 A new start edge detected in IDLE on the clock right after STOP completes SHALL be accepted (back-to-back frames).
REQ-025 Baud_select changes mid-frame are not supported; behaviour limited to completing or aborting the frame without lockup.

Reset
REQ-026 reset=0: state OFF, counters 0, shift register 0, synchronizer flops 1, Rx_DATA=8'h00, Rx_VALID=0, Rx_PERROR=0, Rx_FERROR=0.
REQ-027 Reset asserted mid-frame SHALL abort immediately with no Rx_VALID; after release receiver starts in OFF.

Verification
REQ-028 Rx_EN=1, transmitter loop-back sends 8'hA5 (parity 0) -> Rx_DATA=8'hA5, one Rx_VALID pulse, both errors 0.
REQ-029 Frame 8'h01 with parity bit forced 0 -> Rx_PERROR=1, Rx_FERROR=0, Rx_DATA keeps previous value, no Rx_VALID.
REQ-030 Frame 8'h55 with stop bit 0, then RxD held low 3 bit periods -> Rx_FERROR=1, no further frames until RxD returns 1.
REQ-031 RxD low pulse of 4 sample_ENABLE ticks in IDLE -> return to IDLE, no Rx_VALID, flags 0.
REQ-032 Back-to-back frames 8'h00 then 8'hFF, no idle gap -> two Rx_VALID pulses, Rx_DATA=8'h00 then 8'hFF.
REQ-033 Rx_EN dropped during D3 of a frame, then re-enabled and 8'h3C sent -> no Rx_VALID for aborted frame, Rx_DATA=8'h3C after second.

Source files
------------

// File: rtl/uart_receiver_if.sv
// Receiver-side signal bundle: line input and enable in, received byte and status out.
interface uart_receiver_if;
    logic [2:0] baud_select;
    logic       rx_en;
    logic       rxd;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_perror;
    logic       rx_ferror;

    modport master (
        output baud_select, rx_en, rxd,
        input  rx_data, rx_valid, rx_perror, rx_ferror
    );

    modport slave (
        input  baud_select, rx_en, rxd,
        output rx_data, rx_valid, rx_perror, rx_ferror
    );
endinterface

// File: rtl/uart_receiver.sv
// UART receiver: 8 data bits, even parity, one stop bit, 16x oversampling.
// The baud tick generator lives in the same file and is private to the receiver.

module uart_baud_controller #(
    parameter int unsigned CLK_HZ = 50_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] baud_select,
    output logic       sample_enable
);
    logic [15:0] div_m1;
    logic [15:0] cnt_q;

    function automatic logic [15:0] div_m1_for(input logic [2:0] sel);
        int unsigned baud;
        int unsigned div;
        case (sel)
            3'd0:    baud = 300;
            3'd1:    baud = 1200;
            3'd2:    baud = 4800;
            3'd3:    baud = 9600;
            3'd4:    baud = 19200;
            3'd5:    baud = 38400;
            3'd6:    baud = 57600;
            default: baud = 115200;
        endcase
        div = CLK_HZ / (baud * 16);
        if (div < 1) div = 1;
        return 16'(div - 1);
    endfunction

    assign div_m1 = div_m1_for(baud_select);

    // Down-counter; a rate change that leaves the count above the new reload is clamped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q         <= '0;
            sample_enable <= 1'b0;
        end else if (cnt_q == 16'd0) begin
            cnt_q         <= div_m1;
            sample_enable <= 1'b1;
        end else begin
            cnt_q         <= (cnt_q > div_m1) ? div_m1 : cnt_q - 16'd1;
            sample_enable <= 1'b0;
        end
    end
endmodule

// state  | meaning
// OFF    | receiver disabled, outputs held
// IDLE   | line watched for a start edge (or for a return high after a break)
// START  | verifying the start bit at its midpoint
// DATA   | sampling D0..D7 at each bit midpoint
// PARITY | sampling the parity bit
// STOP   | sampling the stop bit and publishing the result
module uart_receiver #(
    parameter int unsigned CLK_HZ = 50_000_000
) (
    input  logic            clk,
    input  logic            rst_n,
    uart_receiver_if.slave  rx
);
    typedef enum logic [2:0] {
        S_OFF, S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  os_cnt_q, os_cnt_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  data_q, data_d;
    logic        perr_q, perr_d;
    logic        wait_high_q, wait_high_d;
    logic        valid_q, valid_d;
    logic        perror_q, perror_d;
    logic        ferror_q, ferror_d;
    logic        rxd_meta, rxd_s;
    logic        tick;

    uart_baud_controller #(.CLK_HZ(CLK_HZ)) u_baud (
        .clk           (clk),
        .rst_n         (rst_n),
        .baud_select   (rx.baud_select),
        .sample_enable (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxd_meta <= 1'b1;
            rxd_s    <= 1'b1;
        end else begin
            rxd_meta <= rx.rxd;
            rxd_s    <= rxd_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_OFF;
            os_cnt_q    <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            perr_q      <= 1'b0;
            wait_high_q <= 1'b0;
            valid_q     <= 1'b0;
            perror_q    <= 1'b0;
            ferror_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            os_cnt_q    <= os_cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            perr_q      <= perr_d;
            wait_high_q <= wait_high_d;
            valid_q     <= valid_d;
            perror_q    <= perror_d;
            ferror_q    <= ferror_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        os_cnt_d    = os_cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        data_d      = data_q;
        perr_d      = perr_q;
        wait_high_d = wait_high_q;
        valid_d     = 1'b0;
        perror_d    = perror_q;
        ferror_d    = ferror_q;

        if (!rx.rx_en) begin
            state_d     = S_OFF;
            wait_high_d = 1'b0;
        end else begin
            case (state_q)
                S_OFF: state_d = S_IDLE;
                S_IDLE: begin
                    // After a framing error the line must go high before a new start counts.
                    if (wait_high_q) begin
                        if (rxd_s) wait_high_d = 1'b0;
                    end else if (!rxd_s) begin
                        state_d  = S_START;
                        os_cnt_d = '0;
                        perror_d = 1'b0;
                        ferror_d = 1'b0;
                    end
                end
                S_START: begin
                    if (tick) begin
                        if (os_cnt_q == 4'd7) begin
                            os_cnt_d  = '0;
                            bit_idx_d = '0;
                            state_d   = rxd_s ? S_IDLE : S_DATA;
                        end else begin
                            os_cnt_d = os_cnt_q + 4'd1;
                        end
                    end
                end
                S_DATA: begin
                    if (tick) begin
                        os_cnt_d = os_cnt_q + 4'd1;
                        if (os_cnt_q == 4'd15) begin
                            shift_d[bit_idx_q] = rxd_s;
                            if (bit_idx_q == 3'd7) state_d = S_PARITY;
                            else                   bit_idx_d = bit_idx_q + 3'd1;
                        end
                    end
                end
                S_PARITY: begin
                    if (tick) begin
                        os_cnt_d = os_cnt_q + 4'd1;
                        if (os_cnt_q == 4'd15) begin
                            perr_d  = rxd_s ^ (^shift_q);
                            state_d = S_STOP;
                        end
                    end
                end
                S_STOP: begin
                    if (tick) begin
                        os_cnt_d = os_cnt_q + 4'd1;
                        if (os_cnt_q == 4'd15) begin
                            state_d = S_IDLE;
                            if (!rxd_s) begin
                                ferror_d    = 1'b1;
                                perror_d    = perr_q;
                                wait_high_d = 1'b1;
                            end else if (perr_q) begin
                                perror_d = 1'b1;
                            end else begin
                                data_d  = shift_q;
                                valid_d = 1'b1;
                            end
                        end
                    end
                end
                default: state_d = S_OFF;
            endcase
        end
    end

    assign rx.rx_data   = data_q;
    assign rx.rx_valid  = valid_q;
    assign rx.rx_perror = perror_q;
    assign rx.rx_ferror = ferror_q;
endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboarded bench: frames are driven bit by bit, expected bytes queued, a monitor checks each valid pulse.
module tb_uart_receiver;
    localparam int unsigned CLK_HZ = 14_745_600;
    localparam int BIT = 128;   // 8 clocks per tick at 115200, 16 ticks per bit

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    logic [7:0] exp_q[$];
    logic [7:0] last_good;
    logic       exp_perr, exp_ferr;
    logic       prev_valid = 1'b0;

    uart_receiver_if rx();

    uart_receiver #(.CLK_HZ(CLK_HZ)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rx    (rx)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rx.rx_valid) begin
            if (prev_valid) check("rx_valid pulse width", 32'd2, 32'd1);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected rx_valid: got data %0h expected no pulse", rx.rx_data);
            end else begin
                check("scoreboard rx_data", {24'd0, rx.rx_data}, {24'd0, exp_q.pop_front()});
            end
        end
        prev_valid = rx.rx_valid;
    end

    task automatic drive_bit(input logic b, input int n);
        rx.rxd = b;
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic even_parity(input logic [7:0] d);
        return logic'($countones(d) % 2);
    endfunction

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
        logic bad_par;
        bad_par = (par != even_parity(d));
        if (stop && !bad_par) exp_q.push_back(d);
        drive_bit(1'b0, BIT);
        for (int i = 0; i < 8; i++) drive_bit(d[i], BIT);
        drive_bit(par, BIT);
        drive_bit(stop, BIT);
        exp_perr = bad_par;
        exp_ferr = !stop;
        if (stop && !bad_par) last_good = d;
    endtask

    task automatic check_flags(input string tag);
        @(negedge clk);
        check({tag, " rx_data"},   {24'd0, rx.rx_data}, {24'd0, last_good});
        check({tag, " rx_perror"}, {31'd0, rx.rx_perror}, {31'd0, exp_perr});
        check({tag, " rx_ferror"}, {31'd0, rx.rx_ferror}, {31'd0, exp_ferr});
    endtask

    initial begin
        logic [7:0] d;
        logic       par, stop;
        int         low_drop;

        rst_n = 1'b0;
        rx.rx_en = 1'b0;
        rx.rxd = 1'b1;
        rx.baud_select = 3'b111;
        last_good = 8'h00;
        exp_perr = 1'b0;
        exp_ferr = 1'b0;
        repeat (4) @(negedge clk);
        check("reset rx_data",   {24'd0, rx.rx_data}, 32'h00);
        check("reset rx_valid",  {31'd0, rx.rx_valid}, 32'd0);
        check("reset rx_perror", {31'd0, rx.rx_perror}, 32'd0);
        check("reset rx_ferror", {31'd0, rx.rx_ferror}, 32'd0);
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1 rx.rx_en = 1'b1;
        repeat (20) @(posedge clk);
        #1;

        send_frame(8'hA5, 1'b0, 1'b1);
        check_flags("a5");

        send_frame(8'h01, 1'b0, 1'b1);
        check_flags("parity err");

        // Break: stop bit low, line stays low three more bit periods; no new frame may start.
        send_frame(8'h55, 1'b0, 1'b0);
        check_flags("framing err");
        low_drop = 0;
        for (int i = 0; i < 3 * BIT; i++) begin
            @(negedge clk);
            if (!rx.rx_ferror) low_drop++;
        end
        check("ferror held during break", low_drop, 0);
        #1 drive_bit(1'b1, 40);
        check_flags("after break release");

        // Short low glitch: false start clears flags, no byte.
        drive_bit(1'b0, 32);
        drive_bit(1'b1, 2 * BIT);
        exp_perr = 1'b0;
        exp_ferr = 1'b0;
        check_flags("glitch");

        send_frame(8'h96, 1'b0, 1'b1);
        check_flags("recover");

        send_frame(8'h00, 1'b0, 1'b1);
        send_frame(8'hFF, 1'b0, 1'b1);
        check_flags("back to back");
        drive_bit(1'b1, 20);

        // Disable during D3 of 0xC3, then re-enable and receive 0x3C.
        d = 8'hC3;
        drive_bit(1'b0, BIT);
        for (int i = 0; i < 3; i++) drive_bit(d[i], BIT);
        drive_bit(d[3], BIT / 2);
        rx.rx_en = 1'b0;
        drive_bit(1'b1, 200);
        check_flags("abort");
        rx.rx_en = 1'b1;
        drive_bit(1'b1, 20);
        send_frame(8'h3C, 1'b0, 1'b1);
        check_flags("after abort");

        // Reset in the middle of a frame.
        drive_bit(1'b0, BIT);
        drive_bit(1'b1, BIT);
        drive_bit(1'b0, BIT / 2);
        rst_n = 1'b0;
        rx.rxd = 1'b1;
        @(negedge clk);
        check("mid reset rx_data",  {24'd0, rx.rx_data}, 32'h00);
        check("mid reset rx_valid", {31'd0, rx.rx_valid}, 32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        last_good = 8'h00;
        exp_perr = 1'b0;
        exp_ferr = 1'b0;
        check_flags("post reset");
        drive_bit(1'b1, 20);

        for (int n = 0; n < 14; n++) begin
            d = 8'($urandom);
            par = even_parity(d) ^ ($urandom_range(0, 4) == 0);
            stop = ($urandom_range(0, 5) != 0);
            send_frame(d, par, stop);
            check_flags("random");
            if (!stop) drive_bit(1'b1, 20 + $urandom_range(0, 40));
            else if ($urandom_range(0, 1) == 1) drive_bit(1'b1, $urandom_range(1, 60));
        end

        drive_bit(1'b1, 50);
        for (int i = 0; i < 2000 && exp_q.size() != 0; i++) @(negedge clk);
        check("scoreboard drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
